// File: rtl/mips_pkg.sv
// Shared constants and load-type encodings for the MIPS datapath.
package mips_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_AW = 5;
   localparam logic [REG_AW-1:0] REG_ZERO = '0;

   typedef enum logic [2:0] {
      LT_LW  = 3'd0,
      LT_LB  = 3'd1,
      LT_LBU = 3'd2,
      LT_LH  = 3'd3,
      LT_LHU = 3'd4
   } load_type_e;

endpackage

// File: rtl/load_align.sv
// Little-endian load extraction: picks a byte/halfword lane out of the raw
// memory word and sign- or zero-extends it; unknown types pass the word through.
module load_align
   import mips_pkg::*;
(
   input  logic [31:0] mem_data,
   input  logic [1:0]  byte_off,
   input  logic [2:0]  load_type,
   output logic [31:0] aligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = mem_data[7:0];
      case (byte_off)
         2'd0:    byte_sel = mem_data[7:0];
         2'd1:    byte_sel = mem_data[15:8];
         2'd2:    byte_sel = mem_data[23:16];
         default: byte_sel = mem_data[31:24];
      endcase
   end

   // Halfword lane comes from byte_off[1] only; byte_off[0] is ignored.
   assign half_sel = byte_off[1] ? mem_data[31:16] : mem_data[15:0];

   always_comb begin
      aligned = mem_data;
      case (load_type)
         LT_LB:   aligned = {{24{byte_sel[7]}}, byte_sel};
         LT_LBU:  aligned = {24'd0, byte_sel};
         LT_LH:   aligned = {{16{half_sel[15]}}, half_sel};
         LT_LHU:  aligned = {16'd0, half_sel};
         default: aligned = mem_data;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register driving the register-file write port and the
// EX-stage forwarding tap; all outputs come straight from flops.
module wb_stage
   import mips_pkg::*;
#(
   parameter int unsigned DATA_W = mips_pkg::DATA_W,
   parameter int unsigned REG_AW = mips_pkg::REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   input  logic              in_regWrite,
   input  logic              in_memToReg,
   input  logic [2:0]        in_loadType,
   input  logic [1:0]        in_byteOff,
   input  logic [REG_AW-1:0] in_writeReg,
   input  logic [DATA_W-1:0] in_aluResult,
   input  logic [DATA_W-1:0] in_memData,
   output logic              wb_valid,
   output logic              regWrite,
   output logic [REG_AW-1:0] writeReg,
   output logic [DATA_W-1:0] writeData,
   output logic              fwd_valid,
   output logic [REG_AW-1:0] fwd_reg,
   output logic [DATA_W-1:0] fwd_data
);

   logic              valid_q,      valid_d;
   logic              reg_write_q,  reg_write_d;
   logic [REG_AW-1:0] write_reg_q,  write_reg_d;
   logic [DATA_W-1:0] write_data_q, write_data_d;

   logic [DATA_W-1:0] load_word;
   logic              write_en;

   load_align u_load_align (
      .mem_data  (in_memData),
      .byte_off  (in_byteOff),
      .load_type (in_loadType),
      .aligned   (load_word)
   );

   // Register 0 is hardwired zero, so writes to it never reach the file.
   assign write_en = in_valid & in_regWrite & (in_writeReg != REG_AW'(REG_ZERO));

   always_comb begin
      valid_d      = valid_q;
      reg_write_d  = reg_write_q;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;
      if (flush) begin
         valid_d      = 1'b0;
         reg_write_d  = 1'b0;
         write_reg_d  = '0;
         write_data_d = '0;
      end else if (!stall) begin
         valid_d      = in_valid;
         reg_write_d  = write_en;
         write_reg_d  = in_writeReg;
         write_data_d = in_memToReg ? load_word : in_aluResult;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q      <= 1'b0;
         reg_write_q  <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         valid_q      <= valid_d;
         reg_write_q  <= reg_write_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   assign wb_valid  = valid_q;
   assign regWrite  = reg_write_q;
   assign writeReg  = write_reg_q;
   assign writeData = write_data_q;
   assign fwd_valid = reg_write_q;
   assign fwd_reg   = write_reg_q;
   assign fwd_data  = write_data_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: vector table for extraction/select/zero-register
// cases, plus hand sequences for reset, stall/flush and back-to-back writes.
module tb_wb_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        in_valid;
   logic        in_regWrite;
   logic        in_memToReg;
   logic [2:0]  in_loadType;
   logic [1:0]  in_byteOff;
   logic [4:0]  in_writeReg;
   logic [31:0] in_aluResult;
   logic [31:0] in_memData;
   logic        wb_valid;
   logic        regWrite;
   logic [4:0]  writeReg;
   logic [31:0] writeData;
   logic        fwd_valid;
   logic [4:0]  fwd_reg;
   logic [31:0] fwd_data;

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] rf [32];

   wb_stage dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_regWrite  (in_regWrite),
      .in_memToReg  (in_memToReg),
      .in_loadType  (in_loadType),
      .in_byteOff   (in_byteOff),
      .in_writeReg  (in_writeReg),
      .in_aluResult (in_aluResult),
      .in_memData   (in_memData),
      .wb_valid     (wb_valid),
      .regWrite     (regWrite),
      .writeReg     (writeReg),
      .writeData    (writeData),
      .fwd_valid    (fwd_valid),
      .fwd_reg      (fwd_reg),
      .fwd_data     (fwd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream register file: commits on the negedge of the write cycle.
   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      end else if (regWrite) begin
         rf[writeReg] <= writeData;
      end
   end

   typedef struct {
      string       name;
      logic        valid;
      logic        rw;
      logic        m2r;
      logic [2:0]  lt;
      logic [1:0]  off;
      logic [4:0]  wr;
      logic [31:0] alu;
      logic [31:0] mem;
      logic        exp_valid;
      logic        exp_rw;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs [14];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                        input logic [1:0] off, input logic [4:0] wr, input logic [31:0] alu,
                        input logic [31:0] mem);
      in_valid     = v;
      in_regWrite  = rw;
      in_memToReg  = m2r;
      in_loadType  = lt;
      in_byteOff   = off;
      in_writeReg  = wr;
      in_aluResult = alu;
      in_memData   = mem;
   endtask

   task automatic check(input string name, input logic ev, input logic erw, input logic [4:0] ewr,
                        input logic [31:0] ewd);
      n_vec++;
      if (wb_valid !== ev || regWrite !== erw || writeReg !== ewr || writeData !== ewd ||
          fwd_valid !== erw || fwd_reg !== ewr || fwd_data !== ewd) begin
         n_err++;
         $display("FAIL %s: got v=%b rw=%b wr=%0d wd=%h fwd=%b/%0d/%h, want v=%b rw=%b wr=%0d wd=%h",
                  name, wb_valid, regWrite, writeReg, writeData, fwd_valid, fwd_reg, fwd_data,
                  ev, erw, ewr, ewd);
      end
   endtask

   task automatic check_rf(input string name, input int idx, input logic [31:0] exp);
      n_vec++;
      if (rf[idx] !== exp) begin
         n_err++;
         $display("FAIL %s: r%0d got %h, want %h", name, idx, rf[idx], exp);
      end
   endtask

   initial begin
      vecs[0]  = '{"alu_r8",    1, 1, 0, 3'd0, 2'd0, 5'd8,  32'h0000_1234, 32'h0,
                   1, 1, 32'h0000_1234};
      vecs[1]  = '{"lb_off3",   1, 1, 1, 3'd1, 2'd3, 5'd9,  32'h0, 32'h80FF_7F01,
                   1, 1, 32'hFFFF_FF80};
      vecs[2]  = '{"lbu_off3",  1, 1, 1, 3'd2, 2'd3, 5'd10, 32'h0, 32'h80FF_7F01,
                   1, 1, 32'h0000_0080};
      vecs[3]  = '{"lb_off1",   1, 1, 1, 3'd1, 2'd1, 5'd11, 32'h0, 32'h80FF_7F01,
                   1, 1, 32'h0000_007F};
      vecs[4]  = '{"lh_off2",   1, 1, 1, 3'd3, 2'd2, 5'd12, 32'h0, 32'h80FF_7F01,
                   1, 1, 32'hFFFF_80FF};
      vecs[5]  = '{"lhu_off0",  1, 1, 1, 3'd4, 2'd0, 5'd13, 32'h0, 32'h80FF_7F01,
                   1, 1, 32'h0000_7F01};
      vecs[6]  = '{"lw_off2",   1, 1, 1, 3'd0, 2'd2, 5'd14, 32'h0, 32'h80FF_7F01,
                   1, 1, 32'h80FF_7F01};
      vecs[7]  = '{"type6",     1, 1, 1, 3'd6, 2'd1, 5'd15, 32'h0, 32'h80FF_7F01,
                   1, 1, 32'h80FF_7F01};
      vecs[8]  = '{"zero_reg",  1, 1, 0, 3'd0, 2'd0, 5'd0,  32'hDEAD_BEEF, 32'h0,
                   1, 0, 32'hDEAD_BEEF};
      vecs[9]  = '{"bubble",    0, 1, 0, 3'd0, 2'd0, 5'd7,  32'h0000_0077, 32'h0,
                   0, 0, 32'h0000_0077};
      vecs[10] = '{"alu_ign_lt", 1, 1, 0, 3'd1, 2'd3, 5'd16, 32'hCAFE_0001, 32'h80FF_7F01,
                   1, 1, 32'hCAFE_0001};
      vecs[11] = '{"lhu_off3",  1, 1, 1, 3'd4, 2'd3, 5'd17, 32'h0, 32'h80FF_7F01,
                   1, 1, 32'h0000_80FF};
      vecs[12] = '{"lb_off0",   1, 1, 1, 3'd1, 2'd0, 5'd18, 32'h0, 32'h80FF_7F01,
                   1, 1, 32'h0000_0001};
      vecs[13] = '{"lh_off1",   1, 1, 1, 3'd3, 2'd1, 5'd19, 32'h0, 32'h80FF_7F01,
                   1, 1, 32'h0000_7F01};

      rst   = 1'b1;
      stall = 1'b0;
      flush = 1'b0;
      drive(0, 0, 0, 3'd0, 2'd0, 5'd0, 32'h0, 32'h0);
      repeat (2) tick();
      check("reset_hold", 0, 0, 5'd0, 32'h0);
      rst = 1'b0;
      tick();
      check("after_reset_idle", 0, 0, 5'd0, 32'h0);

      // Asynchronous reset between edges clears a live write immediately.
      drive(1, 1, 0, 3'd0, 2'd0, 5'd8, 32'h0000_1234, 32'h0);
      tick();
      check("pre_async_rst", 1, 1, 5'd8, 32'h0000_1234);
      #2 rst = 1'b1;
      #1;
      check("async_rst", 0, 0, 5'd0, 32'h0);
      drive(0, 0, 0, 3'd0, 2'd0, 5'd0, 32'h0, 32'h0);
      @(negedge clk);
      #1 rst = 1'b0;
      tick();
      check("rst_release_idle", 0, 0, 5'd0, 32'h0);

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].valid, vecs[i].rw, vecs[i].m2r, vecs[i].lt, vecs[i].off, vecs[i].wr,
               vecs[i].alu, vecs[i].mem);
         tick();
         check(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_rw, vecs[i].wr, vecs[i].exp_data);
      end
      drive(0, 0, 0, 3'd0, 2'd0, 5'd0, 32'h0, 32'h0);
      tick();
      @(negedge clk);
      #1;
      check_rf("rf_r8", 8, 32'h0000_1234);
      check_rf("rf_r9", 9, 32'hFFFF_FF80);
      check_rf("rf_r0", 0, 32'h0);
      check_rf("rf_r7_bubble", 7, 32'h0);

      // Stall holds contents for three cycles, then flush beats stall.
      drive(1, 1, 0, 3'd0, 2'd0, 5'd5, 32'h0000_0055, 32'h0);
      tick();
      check("load_r5", 1, 1, 5'd5, 32'h0000_0055);
      stall = 1'b1;
      drive(1, 1, 0, 3'd0, 2'd0, 5'd6, 32'h0000_0066, 32'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_hold", 1, 1, 5'd5, 32'h0000_0055);
         in_aluResult = in_aluResult + 32'h1;
      end
      @(negedge clk);
      #1;
      check_rf("rf_r5_stall", 5, 32'h0000_0055);
      check_rf("rf_r6_not_written", 6, 32'h0);
      flush = 1'b1;
      tick();
      check("flush_over_stall", 0, 0, 5'd0, 32'h0);
      flush = 1'b0;

      // Reset during stall: stage stays empty until a real load edge.
      stall = 1'b0;
      drive(1, 1, 0, 3'd0, 2'd0, 5'd5, 32'h0000_0099, 32'h0);
      tick();
      stall = 1'b1;
      #2 rst = 1'b1;
      #1;
      check("rst_mid_stall", 0, 0, 5'd0, 32'h0);
      #1 rst = 1'b0;
      tick();
      check("post_rst_stalled", 0, 0, 5'd0, 32'h0);
      stall = 1'b0;
      drive(1, 1, 0, 3'd0, 2'd0, 5'd9, 32'h0000_0009, 32'h0);
      tick();
      check("post_rst_load", 1, 1, 5'd9, 32'h0000_0009);

      // Back-to-back writes r3<-1, r4<-2, r3<-3.
      drive(1, 1, 0, 3'd0, 2'd0, 5'd3, 32'd1, 32'h0);
      tick();
      check("b2b_r3_1", 1, 1, 5'd3, 32'd1);
      drive(1, 1, 0, 3'd0, 2'd0, 5'd4, 32'd2, 32'h0);
      @(negedge clk);
      #1;
      check_rf("rf_b2b_r3_1", 3, 32'd1);
      tick();
      check("b2b_r4_2", 1, 1, 5'd4, 32'd2);
      drive(1, 1, 0, 3'd0, 2'd0, 5'd3, 32'd3, 32'h0);
      @(negedge clk);
      #1;
      check_rf("rf_b2b_r4_2", 4, 32'd2);
      check_rf("rf_b2b_r3_still1", 3, 32'd1);
      tick();
      check("b2b_r3_3", 1, 1, 5'd3, 32'd3);
      drive(0, 0, 0, 3'd0, 2'd0, 5'd0, 32'h0, 32'h0);
      @(negedge clk);
      #1;
      check_rf("rf_b2b_r3_3", 3, 32'd3);
      tick();
      check("idle_end", 0, 0, 5'd0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
